// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply staging unit.
// Consumed by hilo_if, settle_counter and hilo_unit.
package hilo_pkg;

    localparam int HILO_WIDTH         = 32;
    localparam int HILO_SETTLE_CYCLES = 4;
    localparam int HILO_CNT_W         = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } hilo_state_t;

    // The counter is loaded with SETTLE_CYCLES-1 so capture lands on edge SETTLE_CYCLES.
    function automatic logic [HILO_CNT_W-1:0] settle_load(input int cycles);
        return HILO_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Operand/result bundle between the control side, the multiplier and hilo_unit.
// master = control/multiplier side, slave = hilo_unit.
interface hilo_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   mul_q;
    logic [WIDTH-1:0]   mul_m;
    logic [2*WIDTH-1:0] mul_product;
    logic               hi_wr;
    logic               lo_wr;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH-1:0]   hi_out;
    logic [WIDTH-1:0]   lo_out;
    logic               busy;
    logic               done;
    logic               wr_err;

    modport master (
        output start, a_in, b_in, mul_product, hi_wr, lo_wr, wr_data,
        input  mul_q, mul_m, hi_out, lo_out, busy, done, wr_err
    );

    modport slave (
        input  start, a_in, b_in, mul_product, hi_wr, lo_wr, wr_data,
        output mul_q, mul_m, hi_out, lo_out, busy, done, wr_err
    );

endinterface

// File: rtl/hilo_unit_settle_counter.sv
// settle_counter: loadable down-counter with a zero flag that times the
// multiplier settle interval. Saturates at zero.
module settle_counter
    import hilo_pkg::*;
#(
    parameter int CW = HILO_CNT_W
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: stages operands for the Booth multiplier, captures the product into HI/LO
// after SETTLE_CYCLES, and serves MTHI/MTLO writes. Optional: HILO_ZERO_BYPASS_EN.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH         = HILO_WIDTH,
    parameter int SETTLE_CYCLES = HILO_SETTLE_CYCLES
) (
    input  logic  clock,
    input  logic  clear,
    hilo_if.slave bus
);

    hilo_state_t            state_reg, state_next;
    logic [WIDTH-1:0]       mul_q_reg, mul_m_reg;
    logic [WIDTH-1:0]       hi_reg, lo_reg;
    logic                   done_reg, wr_err_reg;
    logic                   accept, cnt_load, cnt_dec, capture, zero_capture, wr_drop;
    logic [HILO_CNT_W-1:0]  cnt_value;
    logic                   cnt_zero;

    settle_counter #(.CW(HILO_CNT_W)) u_settle (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (settle_load(SETTLE_CYCLES)),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

`ifdef HILO_ZERO_BYPASS_EN
    // A zero-operand start is remembered for one cycle so its zero result
    // lands on edge 1 without ever entering RUN.
    logic zero_pend_reg;
    logic zero_start;

    assign zero_start   = accept && ((bus.a_in == '0) || (bus.b_in == '0));
    assign zero_capture = zero_pend_reg;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            zero_pend_reg <= 1'b0;
        end else begin
            zero_pend_reg <= zero_start;
        end
    end
`else
    logic zero_start;

    assign zero_start   = 1'b0;
    assign zero_capture = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
`ifdef HILO_ZERO_BYPASS_EN
                    if (!((bus.a_in == '0) || (bus.b_in == '0))) begin
                        state_next = RUN;
                        cnt_load   = 1'b1;
                    end
`else
                    state_next = RUN;
                    cnt_load   = 1'b1;
`endif
                end
            end
            RUN: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_drop = (state_reg == RUN) && (bus.hi_wr || bus.lo_wr);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg  <= IDLE;
            mul_q_reg  <= '0;
            mul_m_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            done_reg   <= capture || zero_capture;
            wr_err_reg <= wr_drop;
            if (accept) begin
                mul_q_reg <= bus.a_in;
                mul_m_reg <= bus.b_in;
            end
            // Captured results take priority over a direct write in the same cycle.
            if (capture) begin
                hi_reg <= bus.mul_product[2*WIDTH-1:WIDTH];
                lo_reg <= bus.mul_product[WIDTH-1:0];
            end else if (zero_capture) begin
                hi_reg <= '0;
                lo_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (bus.hi_wr) hi_reg <= bus.wr_data;
                if (bus.lo_wr) lo_reg <= bus.wr_data;
            end
        end
    end

    assign bus.mul_q  = mul_q_reg;
    assign bus.mul_m  = mul_m_reg;
    assign bus.hi_out = hi_reg;
    assign bus.lo_out = lo_reg;
    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = done_reg;
    assign bus.wr_err = wr_err_reg;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed scoreboard bench for hilo_unit: expected HI/LO are queued at start
// and popped when done pulses. The bench acts as the combinational multiplier.
module tb_hilo_unit;

`ifdef HILO_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int ZERO_LAT = BYPASS ? 1 : 4;

    logic clock;
    logic clear;
    int   n_pass;
    int   n_fail;
    int   n_total;
    logic [63:0] exp_q[$];

    hilo_if #(.WIDTH(32)) bus ();

    hilo_unit #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    assign bus.mul_product = model_mul(bus.mul_q, bus.mul_m);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a start for one cycle; sampled after the accepting edge (edge 0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] expv, input bit push, input bit busy_exp);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        if (push) exp_q.push_back(expv);
        tick();
        bus.start = 1'b0;
        check("start_busy", 64'(bus.busy), 64'(busy_exp));
        check("start_mul_q", 64'(bus.mul_q), 64'(a));
        $display("start a=%h b=%h", a, b);
    endtask

    // Wait (bounded) for done and compare against the scoreboard head.
    task automatic wait_done(input int lat, input string tag);
        int   k;
        bit   seen;
        logic [63:0] expv;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(lat));
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check({tag, "_hi"}, 64'(bus.hi_out), 64'(expv[63:32]));
        check({tag, "_lo"}, 64'(bus.lo_out), 64'(expv[31:0]));
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, "_wr_err_quiet"}, 64'(bus.wr_err), 64'd0);
        $display("%s: done after %0d edges hi=%h lo=%h", tag, k, bus.hi_out, bus.lo_out);
    endtask

    task automatic direct_write(input bit hw, input bit lw, input logic [31:0] d);
        bus.hi_wr   = hw;
        bus.lo_wr   = lw;
        bus.wr_data = d;
        tick();
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
    endtask

    initial begin
        bit saw_done;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.a_in    = '0;
        bus.b_in    = '0;
        bus.hi_wr   = 1'b0;
        bus.lo_wr   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clock);
        #1 clear = 1'b0;
        tick();

        check("rst_mul_q", 64'(bus.mul_q), 64'd0);
        check("rst_mul_m", 64'(bus.mul_m), 64'd0);
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_wr_err", 64'(bus.wr_err), 64'd0);
        $display("reset released");

        direct_write(1'b1, 1'b0, 32'hDEADBEEF);
        check("mthi_hi", 64'(bus.hi_out), 64'h0000_0000_DEAD_BEEF);
        check("mthi_lo", 64'(bus.lo_out), 64'd0);
        $display("mthi hi=%h lo=%h", bus.hi_out, bus.lo_out);

        direct_write(1'b1, 1'b1, 32'h0BADF00D);
        check("both_hi", 64'(bus.hi_out), 64'h0000_0000_0BAD_F00D);
        check("both_lo", 64'(bus.lo_out), 64'h0000_0000_0BAD_F00D);
        $display("mthi+mtlo hi=%h lo=%h", bus.hi_out, bus.lo_out);

        // 7 * -3 with an ignored start and a dropped MTLO mid-run.
        start_op(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b1);
        tick();
        bus.start   = 1'b1;
        bus.a_in    = 32'd5;
        bus.lo_wr   = 1'b1;
        bus.wr_data = 32'h5555_5555;
        tick();
        bus.start = 1'b0;
        bus.lo_wr = 1'b0;
        check("midrun_wr_err", 64'(bus.wr_err), 64'd1);
        check("midrun_mul_q", 64'(bus.mul_q), 64'd7);
        check("midrun_lo_kept", 64'(bus.lo_out), 64'h0000_0000_0BAD_F00D);
        check("midrun_busy", 64'(bus.busy), 64'd1);
        $display("midrun start+mtlo: wr_err=%b mul_q=%h", bus.wr_err, bus.mul_q);
        wait_done(2, "mul_7x-3");

        // Back-to-back: next start issued in the done cycle.
        start_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 1'b1);
        wait_done(4, "mul_b2b");

        // Direct write together with start: write lands, capture overwrites later.
        bus.hi_wr   = 1'b1;
        bus.wr_data = 32'hCAFE_0000;
        start_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1, 1'b1);
        bus.hi_wr = 1'b0;
        check("wr_with_start_hi", 64'(bus.hi_out), 64'h0000_0000_CAFE_0000);
        wait_done(4, "mul_3x5");

        // Abort mid-run with clear.
        direct_write(1'b1, 1'b1, 32'h1357_9BDF);
        start_op(32'h1234, 32'h5678, 64'd0, 1'b0, 1'b1);
        tick();
        #3 clear = 1'b1;
        #1;
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_hi", 64'(bus.hi_out), 64'd0);
        check("clr_lo", 64'(bus.lo_out), 64'd0);
        check("clr_mul_q", 64'(bus.mul_q), 64'd0);
        #2 clear = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check("clr_no_done", 64'(saw_done), 64'd0);
        check("clr_idle_busy", 64'(bus.busy), 64'd0);
        $display("clear mid-run: busy=%b done_seen=%b", bus.busy, saw_done);

        // Zero operand: bypass or full settle depending on build.
        direct_write(1'b1, 1'b1, 32'h2468_ACE0);
        start_op(32'd0, 32'h0000_1234, 64'd0, 1'b1, !BYPASS);
        wait_done(ZERO_LAT - 0, "mul_zero");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
